// File: rtl/hazard_control.sv
// Pipeline hazard/stall controller for the 5-stage RV32I core: freeze, branch flush, load-use bubble.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_control #(
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_dec,
    input  logic [4:0]       rs2_dec,
    input  logic [4:0]       rd_exe,
    input  logic             exe_mem_read,
    input  logic             br_taken_mem,
    input  logic             imem_read,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    output logic             load_pc,
    output logic             load_ifid,
    output logic             load_idex,
    output logic             load_exmem,
    output logic             load_memwb,
    output logic             bubble_idex,
    output logic             flush_ifid,
    output logic             if_hold,
    output logic             hang_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] lu_bubbles
);

    typedef enum logic [1:0] {S_RUN, S_IWAIT, S_DWAIT, S_IHELD} state_t;

    localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

    state_t      state;
    logic [15:0] wd_cnt;
    logic [15:0] wd_nxt;
    logic        load_use;
    logic        iwait;
    logic        dwait;
    logic        freeze;
    logic        lu_evt;

    assign load_use = exe_mem_read && (rd_exe != 5'd0) &&
                      ((rd_exe == rs1_dec) || (rd_exe == rs2_dec));
    // A latched I-cache response means fetch is no longer waiting on the cache.
    assign iwait    = imem_read && !imem_resp && !if_hold;
    assign dwait    = dmem_req && !dmem_resp;
    assign freeze   = iwait || dwait;
    assign lu_evt   = !rst && !freeze && !br_taken_mem && load_use;

    always_comb begin
        load_pc     = 1'b0;
        load_ifid   = 1'b0;
        load_idex   = 1'b0;
        load_exmem  = 1'b0;
        load_memwb  = 1'b0;
        bubble_idex = 1'b0;
        flush_ifid  = 1'b0;
        if (rst || freeze) begin
            load_pc = 1'b0;
        end else if (br_taken_mem) begin
            // The ID instruction is squashed, so its load-use dependency is moot.
            load_pc     = 1'b1;
            load_ifid   = 1'b1;
            load_idex   = 1'b1;
            load_exmem  = 1'b1;
            load_memwb  = 1'b1;
            bubble_idex = 1'b1;
            flush_ifid  = 1'b1;
        end else if (load_use) begin
            load_idex   = 1'b1;
            load_exmem  = 1'b1;
            load_memwb  = 1'b1;
            bubble_idex = 1'b1;
        end else begin
            load_pc    = 1'b1;
            load_ifid  = 1'b1;
            load_idex  = 1'b1;
            load_exmem = 1'b1;
            load_memwb = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_RUN;
            if_hold <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (dwait && imem_resp) begin
                        state   <= S_IHELD;
                        if_hold <= 1'b1;
                    end else if (dwait) begin
                        state <= S_DWAIT;
                    end else if (iwait) begin
                        state <= S_IWAIT;
                    end
                end
                S_IWAIT: begin
                    if (imem_resp && dwait) begin
                        state   <= S_IHELD;
                        if_hold <= 1'b1;
                    end else if (imem_resp) begin
                        state <= S_RUN;
                    end else if (dwait) begin
                        state <= S_DWAIT;
                    end else if (!iwait) begin
                        state <= S_RUN;
                    end
                end
                S_DWAIT: begin
                    if (!dwait) begin
                        state <= iwait ? S_IWAIT : S_RUN;
                    end else if (imem_resp) begin
                        state   <= S_IHELD;
                        if_hold <= 1'b1;
                    end
                end
                S_IHELD: begin
                    // Hold drops at the edge ending the cycle the pipeline advances.
                    if (!dwait) begin
                        state   <= S_RUN;
                        if_hold <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_RUN;
                    if_hold <= 1'b0;
                end
            endcase
        end
    end

    assign wd_nxt = (wd_cnt == 16'hFFFF) ? wd_cnt : wd_cnt + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt   <= 16'd0;
            hang_err <= 1'b0;
        end else if (freeze) begin
            wd_cnt <= wd_nxt;
            if (wd_nxt >= TO_LIM) hang_err <= 1'b1;
        end else begin
            wd_cnt <= 16'd0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] lu_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            lu_q    <= '0;
        end else begin
            if (freeze) stall_q <= stall_q + CNT_W'(1);
            if (lu_evt) lu_q    <= lu_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_q;
    assign lu_bubbles   = lu_q;
`else
    logic unused_perf;
    assign unused_perf  = lu_evt;
    assign stall_cycles = '0;
    assign lu_bubbles   = '0;
`endif

endmodule

// File: tb/tb_hazard_control.sv
// Randomized + directed self-checking bench for hazard_control against a rule-level reference model.
module tb_hazard_control;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rs1_dec = '0, rs2_dec = '0, rd_exe = '0;
    logic        exe_mem_read = 0, br_taken_mem = 0, imem_read = 0, imem_resp = 0;
    logic        dmem_req = 0, dmem_resp = 0;
    logic        load_pc, load_ifid, load_idex, load_exmem, load_memwb;
    logic        bubble_idex, flush_ifid, if_hold, hang_err;
    logic [31:0] stall_cycles, lu_bubbles;

    hazard_control #(.TIMEOUT(TO), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .rs1_dec(rs1_dec), .rs2_dec(rs2_dec), .rd_exe(rd_exe),
        .exe_mem_read(exe_mem_read), .br_taken_mem(br_taken_mem), .imem_read(imem_read),
        .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
        .load_pc(load_pc), .load_ifid(load_ifid), .load_idex(load_idex),
        .load_exmem(load_exmem), .load_memwb(load_memwb), .bubble_idex(bubble_idex),
        .flush_ifid(flush_ifid), .if_hold(if_hold), .hang_err(hang_err),
        .stall_cycles(stall_cycles), .lu_bubbles(lu_bubbles)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // model: fetch holding a latched response, watchdog run length, sticky error, counters
    bit          m_held = 0, m_hang = 0;
    int          m_wd = 0;
    logic [31:0] m_stall = 0, m_lu = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drv(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input bit emr, input bit br, input bit ir, input bit irsp,
                       input bit dr, input bit drsp);
        rs1_dec = r1; rs2_dec = r2; rd_exe = rd; exe_mem_read = emr; br_taken_mem = br;
        imem_read = ir; imem_resp = irsp; dmem_req = dr; dmem_resp = drsp;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model at the edge.
    task automatic tick();
        bit lu, iw, dw, frz, held_n, hang_n;
        int wd_n;
        logic [7:0] exp, obs;
        logic [31:0] st_n, lu_n;
        @(negedge clk);
        if (rst) begin
            m_held = 0; m_hang = 0; m_wd = 0; m_stall = 0; m_lu = 0;
        end
        lu  = exe_mem_read && rd_exe != 0 && (rd_exe == rs1_dec || rd_exe == rs2_dec);
        iw  = imem_read && !imem_resp && !m_held;
        dw  = dmem_req && !dmem_resp;
        frz = iw || dw;
        // {pc, ifid, idex, exmem, memwb, bubble, flush, if_hold}
        if (rst)               exp = 8'b0;
        else if (frz)          exp = {7'b0000000, m_held};
        else if (br_taken_mem) exp = {7'b1111111, m_held};
        else if (lu)           exp = {7'b0011110, m_held};
        else                   exp = {7'b1111100, m_held};
        obs = {load_pc, load_ifid, load_idex, load_exmem, load_memwb, bubble_idex, flush_ifid, if_hold};
        chk("ctl", {24'b0, obs}, {24'b0, exp});
        chk("hang", {31'b0, hang_err}, {31'b0, m_hang});
        chk("stall_cnt", stall_cycles, m_stall);
        chk("lu_cnt", lu_bubbles, m_lu);
        held_n = dw && (m_held || imem_resp);
        wd_n   = frz ? ((m_wd < 65535) ? m_wd + 1 : m_wd) : 0;
        hang_n = m_hang || (frz && wd_n >= TO);
        st_n   = m_stall;
        lu_n   = m_lu;
`ifdef HAZARD_PERF_CNT_EN
        if (frz) st_n = m_stall + 1;
        if (!frz && !br_taken_mem && lu) lu_n = m_lu + 1;
`endif
        @(posedge clk);
        if (!rst) begin
            m_held = held_n; m_wd = wd_n; m_hang = hang_n; m_stall = st_n; m_lu = lu_n;
        end
        #1;
    endtask

    logic [31:0] exp_st, exp_lu;

    initial begin
        idle();
        rst = 1;
        repeat (2) tick();
        rst = 0;
        tick();

        // load-use on rs2, then the bubble has moved on
        drv(0, 5, 5, 1, 0, 0, 0, 0, 0); tick();
        idle(); tick();
        // load to x0 never stalls
        drv(0, 0, 0, 1, 0, 0, 0, 0, 0); tick();

        // split responses: I-resp in cycle 1, D-resp in cycle 4
        drv(0, 0, 0, 0, 0, 1, 1, 1, 0); tick();
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0); tick(); tick();
        drv(0, 0, 0, 0, 0, 0, 0, 1, 1); tick();
        chk("hold_clr", {31'b0, if_hold}, 32'd0);
        idle(); tick();

        // branch beats load-use; branch waiting behind a freeze
        drv(5, 0, 5, 1, 1, 0, 0, 0, 0); tick();
        drv(0, 0, 0, 0, 1, 0, 0, 1, 0); tick();
        drv(0, 0, 0, 0, 1, 0, 0, 1, 1); tick();
        idle(); tick();

        // async reset while fetch is held
        drv(0, 0, 0, 0, 0, 1, 1, 1, 0); tick();
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
        chk("hold_set", {31'b0, if_hold}, 32'd1);
        #2 rst = 1;
        #1 chk("hold_async", {31'b0, if_hold}, 32'd0);
        tick();
        rst = 0; idle(); tick();

        // watchdog: D-cache never answers
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (7) tick();
        chk("wd_pre", {31'b0, hang_err}, 32'd0);
        tick();
        chk("wd_hit", {31'b0, hang_err}, 32'd1);
        repeat (3) tick();
        drv(0, 0, 0, 0, 0, 0, 0, 1, 1); tick();
        idle(); tick();
        chk("wd_sticky", {31'b0, hang_err}, 32'd1);
        rst = 1; tick();
        chk("wd_rst", {31'b0, hang_err}, 32'd0);
        rst = 0; idle(); tick();

        // counters: 3 freeze cycles, 2 load-use bubbles
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0); repeat (3) tick();
        drv(3, 0, 3, 1, 0, 0, 0, 0, 0); tick();
        idle(); tick();
        drv(0, 7, 7, 1, 0, 0, 0, 0, 0); tick();
        idle(); tick();
`ifdef HAZARD_PERF_CNT_EN
        exp_st = 32'd3; exp_lu = 32'd2;
`else
        exp_st = 32'd0; exp_lu = 32'd0;
`endif
        chk("perf_stall", stall_cycles, exp_st);
        chk("perf_lu", lu_bubbles, exp_lu);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            rst          = ($urandom_range(0, 99) == 0);
            rs1_dec      = 5'($urandom_range(0, 5));
            rs2_dec      = 5'($urandom_range(0, 5));
            rd_exe       = 5'($urandom_range(0, 5));
            exe_mem_read = ($urandom_range(0, 1) == 1);
            br_taken_mem = ($urandom_range(0, 5) == 0);
            imem_read    = ($urandom_range(0, 2) == 0);
            imem_resp    = ($urandom_range(0, 3) == 0);
            dmem_req     = ($urandom_range(0, 2) == 0);
            dmem_resp    = ($urandom_range(0, 2) == 0);
            tick();
        end
        rst = 0; idle(); tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/hazard_control.md
Name: hazard_control

Overview:
- Pipeline hazard and stall controller for the 5-stage RV32I core.
- Sits beside the EX-stage forwarding logic and drives the stage-register load enables and bubble/flush controls.
- Covers load-use hazards that forwarding cannot resolve, I-cache and D-cache wait freezes, and taken-branch flushes.
- Holds a small FSM that latches an early I-cache response while the D-cache is still pending, plus a freeze watchdog.

Parameters:
- TIMEOUT, 1023: consecutive frozen cycles before hang_err sets (range 1..65535).
- CNT_W, 32: width of the optional performance counters.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- rs1_dec  in  5  rs1 index of the instruction in ID
- rs2_dec  in  5  rs2 index of the instruction in ID
- rd_exe  in  5  rd of the instruction in EX
- exe_mem_read  in  1  EX instruction is a load
- br_taken_mem  in  1  branch/jump in MEM redirects the PC
- imem_read  in  1  fetch stage has an outstanding I-cache read
- imem_resp  in  1  I-cache response, single-cycle pulse
- dmem_req  in  1  MEM stage has an outstanding D-cache read/write
- dmem_resp  in  1  D-cache response, single-cycle pulse
- load_pc, load_ifid, load_idex, load_exmem, load_memwb  out  1 each  stage-register load enables
- bubble_idex  out  1  load a NOP control word into ID/EX
- flush_ifid  out  1  clear IF/ID to a NOP
- if_hold  out  1  fetch keeps its latched instruction and must not re-request
- hang_err  out  1  sticky watchdog error
- stall_cycles, lu_bubbles  out  CNT_W each  performance counters (only with the optional feature)

Behaviour:
- Reset: all outputs and registers are 0 while rst is high; the FSM enters S_RUN.
- Derived terms:
  - load_use = exe_mem_read & rd_exe!=0 & (rd_exe==rs1_dec | rd_exe==rs2_dec)
  - iwait = imem_read & !imem_resp & !if_hold
  - dwait = dmem_req & !dmem_resp
  - freeze = iwait | dwait
- FSM states:
  - S_RUN: stay while freeze=0.
    - If dwait and imem_resp occur in the same cycle, go to S_IHELD.
    - If dwait alone, go to S_DWAIT.
    - If iwait alone, go to S_IWAIT.
  - S_IWAIT: imem_resp & !dwait goes to S_RUN; imem_resp & dwait goes to S_IHELD.
  - S_DWAIT: dmem_resp goes to S_RUN, unless iwait is still pending, in which case go to S_IWAIT; imem_resp while still waiting goes to S_IHELD.
  - S_IHELD: if_hold=1; dmem_resp goes to S_RUN; if_hold drops in the same cycle the pipeline advances.
- Priority: freeze > branch flush > load-use.
- Freeze: all load_* = 0; bubble_idex = 0; flush_ifid = 0.
- Branch (no freeze, br_taken_mem=1):
  - all load_* = 1, flush_ifid = 1, bubble_idex = 1.
  - load_use is ignored because the ID instruction is squashed.
- Load-use (no freeze, no branch):
  - load_pc = load_ifid = 0; load_idex = load_exmem = load_memwb = 1; bubble_idex = 1.
  - Costs exactly 1 bubble, after which the MEM→EX forwarding path resolves the dependency.
- Otherwise all load_* = 1 and flush/bubble = 0.
- All enables and flush/bubble outputs are combinational from state + inputs with zero latency; only state, if_hold and counters are registered.
- br_taken_mem arriving during a freeze stays stable (MEM is frozen) and is acted on in the first unfrozen cycle.
- rd_exe = 0 never causes a load-use stall.
- Watchdog: a 16-bit counter increments every cycle freeze=1 and clears when freeze=0. When it reaches TIMEOUT, hang_err sets and stays set until rst. The counter saturates and does not wrap.
- Reset mid-freeze: the FSM returns to S_RUN and if_hold clears immediately (asynchronous reset).

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cycles increments on every freeze cycle.
  - lu_bubbles increments on every load-use bubble.
  - Both wrap modulo 2^CNT_W and reset to 0.
- Undefined: the counters are not built; both ports are tied to 0.

Test Plan:
- Load-use: exe_mem_read=1, rd_exe=5, rs2_dec=5, no waits → one cycle with load_pc=0, load_ifid=0, bubble_idex=1; next cycle all enables=1.
- Load to x0: exe_mem_read=1, rd_exe=0, rs1_dec=0 → no stall; all load_*=1.
- Split responses: dmem_req held 4 cycles with dmem_resp on cycle 4, imem_read with imem_resp on cycle 1 → all load_*=0 for cycles 1-3; if_hold=1 on cycles 2-4; cycle 4 advances and if_hold clears.
- Branch beats load-use: br_taken_mem=1 with load_use=1 → all load_*=1, flush_ifid=1, bubble_idex=1 in that cycle.
- Watchdog: TIMEOUT=8, dmem_req held with no response → hang_err rises after 8 frozen cycles and stays high after dmem_resp; rst clears it.
- With HAZARD_PERF_CNT_EN: 3 freeze cycles plus 2 load-use events → stall_cycles=3, lu_bubbles=2.
